// File: rtl/ushreg_pkg.sv
// ushreg_pkg: shared mode, direction, FSM state and register-op encodings for the universal shift register.
package ushreg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    typedef enum logic [1:0] {OP_HOLD, OP_SHR, OP_SHL, OP_LOAD} op_t;

    function automatic op_t mode_op(input logic [1:0] m);
        return m == MODE_SHR ? OP_SHR : m == MODE_SHL ? OP_SHL : m == MODE_LOAD ? OP_LOAD : OP_HOLD;
    endfunction

endpackage

// File: rtl/ushreg_core.sv
// ushreg_core: WIDTH-bit register with hold/shift-right/shift-left/load next-value mux.
// USHREG_ROTATE_EN adds rot, which feeds the outgoing bit back instead of sin.
module ushreg_core import ushreg_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  op_t              op,
    input  logic             sin,
`ifdef USHREG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q
);

    logic             ins_r;
    logic             ins_l;
    logic [WIDTH-1:0] d;

`ifdef USHREG_ROTATE_EN
    assign ins_r = rot ? q[0] : sin;
    assign ins_l = rot ? q[WIDTH-1] : sin;
`else
    assign ins_r = sin;
    assign ins_l = sin;
`endif

    always_comb
        d = op == OP_SHR  ? {ins_r, q[WIDTH-1:1]} :
            op == OP_SHL  ? {q[WIDTH-2:0], ins_l} :
            op == OP_LOAD ? pin : q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else        q <= d;

endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: manual hold/shift/load register plus a self-timed WIDTH-shift burst engine.
// Define USHREG_ROTATE_EN to add the rot input (rotate instead of inserting sin).
module universal_shift_register import ushreg_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             sin,
`ifdef USHREG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             qr,
    output logic             ql,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dir_l;
    op_t           op;

    // Manual mode only reaches the register while idle and not starting a burst.
    always_comb
        op = state == S_SHIFT ? (dir_l == DIR_RIGHT ? OP_SHR : OP_SHL) :
             state == S_DONE  ? OP_HOLD :
             start            ? OP_LOAD : mode_op(mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            dir_l <= DIR_LEFT;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE:
                    if (start) begin
                        state <= S_SHIFT;
                        cnt   <= CW'(WIDTH);
                        dir_l <= dir;
                        busy  <= 1'b1;
                    end
                S_SHIFT: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    ushreg_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .sin   (sin),
`ifdef USHREG_ROTATE_EN
        .rot   (rot),
`endif
        .pin   (pin),
        .q     (q)
    );

    assign qr = q[0];
    assign ql = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed plan scenarios plus random stimulus, checked through a scoreboard
// against a cycle-age reference model; honours USHREG_ROTATE_EN.
module tb_universal_shift_register;

    localparam int W = 4;
`ifdef USHREG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         sin = 1'b0;
    logic         rot = 1'b0;
    logic [W-1:0] pin = '0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] q;
    logic         qr, ql, busy, done;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sin   (sin),
`ifdef USHREG_ROTATE_EN
        .rot   (rot),
`endif
        .pin   (pin),
        .start (start),
        .dir   (dir),
        .q     (q),
        .qr    (qr),
        .ql    (ql),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [W-1:0] q;
        logic         busy, done, ser_v, ser_d, ser_b;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Model: register value as an integer, burst tracked by edges elapsed since the start edge (-1 = idle).
    int m_q = 0;
    int age = -1;
    bit b_dir = 1'b0;
    int b_pin = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int shr(input logic s);
        int ins = (ROT && rot) ? m_q % 2 : int'(s);
        return m_q / 2 + ins * (1 << (W - 1));
    endfunction

    function automatic int shl(input logic s);
        int ins = (ROT && rot) ? m_q / (1 << (W - 1)) : int'(s);
        return (m_q * 2 + ins) % (1 << W);
    endfunction

    task automatic step(input logic [1:0] md, input logic s, input logic r, input logic [W-1:0] p,
                        input logic st, input logic d);
        exp_t e;
        mode = md; sin = s; rot = r; pin = p; start = st; dir = d;
        if (age < 0) begin
            if (st) begin
                m_q = int'(p); b_pin = int'(p); b_dir = d; age = 0;
            end else if (md == 2'd1) m_q = shr(s);
            else if (md == 2'd2) m_q = shl(s);
            else if (md == 2'd3) m_q = int'(p);
        end else if (age < W) begin
            m_q = b_dir ? shr(s) : shl(s);
            age++;
        end else age = -1;
        e.q     = W'(m_q);
        e.busy  = age >= 0 && age < W;
        e.done  = age == W;
        e.ser_v = e.busy;
        e.ser_d = b_dir;
        e.ser_b = e.busy ? ((b_dir ? b_pin >> age : b_pin >> (W - 1 - age)) & 1) != 0 : 1'b0;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        m_q = 0;
        age = -1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", q, e.q);
                chk("busy", busy, e.busy);
                chk("done", done, e.done);
                chk("qr", qr, e.q[0]);
                chk("ql", ql, e.q[W-1]);
                if (e.ser_v) chk("serial", e.ser_d ? qr : ql, e.ser_b);
            end
        end
    end

    initial begin
        logic [3:0] seq;
        #3;
        chk("por_q", q, 0);
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b00, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        chk("hold_after_reset", q, 4'b0000);

        step(2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0); chk("shr1", q, 4'b1000);
        step(2'b01, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0); chk("shr2", q, 4'b0100);
        step(2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0); chk("shr3", q, 4'b1010);
        step(2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0); chk("shr4", q, 4'b1101);
        seq = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            chk("shl_ql", ql, seq[i]);
            step(2'b10, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        end
        chk("shl_final", q, 4'b0000);

        step(2'b00, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1);
        seq = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            chk("bright_qr", qr, seq[i]);
            chk("bright_busy", busy, 1);
            step(2'($urandom), 1'b1, 1'b0, 4'($urandom), i == 1, 1'($urandom));
        end
        chk("bright_done", done, 1);
        chk("bright_q", q, 4'b1111);
        step(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("bright_done_end", done, 0);
        chk("bright_hold", q, 4'b1111);

        step(2'b00, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0);
        seq = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            chk("bleft_ql", ql, seq[i]);
            step(2'b11, 1'b0, 1'b0, 4'($urandom), 1'b0, 1'b1);
        end
        chk("bleft_done", done, 1);
        chk("bleft_q", q, 4'b0000);
        step(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("bleft_done_end", done, 0);

        step(2'b00, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        do_reset();
        step(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("abort_no_done", done, 0);
        chk("abort_busy", busy, 0);
        step(2'b00, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("reburst_busy", busy, 1);
            step(2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        end
        chk("reburst_done", done, 1);
        chk("reburst_q", q, 4'b1111);
        step(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

`ifdef USHREG_ROTATE_EN
        step(2'b00, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
        seq = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            chk("rot_qr", qr, seq[i]);
            step(2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        end
        chk("rot_q", q, 4'b1011);
        step(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        chk("rot_shl", q, 4'b0001);
`endif

        repeat (1500) begin
            if ($urandom_range(199) == 0) do_reset();
            else step(2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                      $urandom_range(5) == 0, 1'($urandom));
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register with hold, shift-right, shift-left and parallel-load modes. It also has a self-timed burst engine that loads a word and shifts it out serially for exactly WIDTH cycles while capturing serial input. It succeeds the fixed 2-mode left/right shift register in the shift-register library. It is the serialiser/deserialiser primitive for the serial-link labs.

## Interface
- WIDTH, 8, register length in bits; legal range ≥ 2
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous, active-low reset
- Mode  input  2  manual operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load; honoured only in IDLE
- Sin  input  1  serial input bit, inserted at MSB on right shift and at LSB on left shift
- Pin  input  WIDTH  parallel load word
- Start  input  1  burst request, sampled only in IDLE
- Dir  input  1  burst direction: 1 right, 0 left; sampled with Start
- Q  output  WIDTH  register contents
- QR  output  1  Q[0], the bit leaving on a right shift
- QL  output  1  Q[WIDTH-1], the bit leaving on a left shift
- Busy  output  1  high while the burst is shifting
- Done  output  1  one-cycle pulse after the last burst shift

## Operation
- Right shift: Q ← {Sin, Q[WIDTH-1:1]}. Left shift: Q ← {Q[WIDTH-2:0], Sin}.
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE with Start=1:
  - Q ← Pin and latch Dir; Mode is ignored on that edge.
  - Cnt ← WIDTH; go to SHIFT.
- IDLE with Start=0: Mode is applied.
- SHIFT:
  - Each edge shifts in the latched direction and Cnt ← Cnt−1.
  - On the edge where Cnt goes 1→0, go to DONE.
  - Mode, Start, Dir and Pin are ignored.
- DONE: Q holds and Done=1; next edge goes to IDLE. Start is ignored in DONE.
- Cnt is $clog2(WIDTH+1) bits wide and never wraps below 0.
- Busy=1 exactly in SHIFT; Done=1 exactly in DONE.
- A burst transmits Pin LSB-first on QR (Dir=1) or MSB-first on QL (Dir=0). It leaves the last WIDTH Sin samples in Q.

## Timing
- Reset values: Q=0, QL=0, QR=0, Busy=0, Done=0, Cnt=0, state IDLE.
- Reset takes effect immediately, independent of Clk.
- Reset mid-burst aborts the burst; no Done pulse follows.
- Manual modes have 1-cycle latency: Q reflects the operation after the sampling edge.
- Burst, with edge 0 the edge that samples Start:
  - After edge 0: Q=Pin, Busy=1, and the first serial bit is visible on QR/QL.
  - Edges 1..WIDTH perform the shifts.
  - After edge WIDTH: Busy=0, Done=1 for one cycle.
  - After edge WIDTH+1: IDLE.
- Back-to-back bursts: minimum Start-to-Start spacing is WIDTH+2 cycles.
- A Start held continuously restarts in the first IDLE cycle.
- QL/QR are combinational from Q, with no extra register stage.

## Configuration
- USHREG_ROTATE_EN defined:
  - Adds input port Rot (1 bit), placed after Sin.
  - When Rot=1, the inserted bit is the bit leaving the opposite end instead of Sin, i.e. rotate. This applies in manual shift modes and in bursts.
  - Rot is sampled every shift edge.
  - A full burst with Rot=1 returns Q to Pin.
- Undefined: no Rot port; Sin is always inserted.

## Structure
- Shared package ushreg_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
  - direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1
  - FSM state encoding S_IDLE, S_SHIFT, S_DONE
- Sub-module ushreg_core: the WIDTH-bit register plus its next-value mux (hold/shr/shl/load, optional rotate).
  - Driven by a decoded op from the top.
  - The top holds the FSM, Cnt and the Dir latch.

## Test plan
All scenarios use WIDTH=4.
- Reset: Rst_n low mid-clock → Q=0000, Busy=0, Done=0 immediately; release → IDLE, Q holds 0000 with Mode=00.
- Manual right shift: Mode=01, Sin=1,0,1,1 on 4 edges → Q=1000, 0100, 1010, 1101. Then Mode=10, Sin=0 for 4 edges → QL reads 1,1,0,1 before each edge; final Q=0000.
- Burst right: Pin=1011, Dir=1, Start pulse, Sin=1 → QR=1,1,0,1 on the 4 cycles after edge 0; Busy high 4 cycles; Done pulse on cycle 5; final Q=1111. Start asserted during Busy is ignored and Q is unaffected.
- Burst left: Pin=1011, Dir=0, Sin=0 → QL=1,0,1,1; Done one cycle; final Q=0000. Mode=11 in SHIFT is ignored.
- Reset mid-burst: Rst_n low after edge 2 → Q=0000, Busy=0, no Done. Next Start runs a full 4-shift burst.
- Rotate (USHREG_ROTATE_EN): Pin=1011, Rot=1, Dir=1 burst → QR=1,1,0,1 and final Q=1011. Manual Mode=10 with Rot=1 on Q=1000 → 0001.
